// File: rtl/mem_write_encoder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_write_encoder_pkg
// Description : Shared store/load definitions. Holds the access-size codes,
//               the store FSM state codes and the alignment check, so the
//               load decoder can flag exactly the same errors.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_write_encoder_pkg;

  // Access size as carried on dataSize (3 is reserved and always rejected)
  typedef enum logic [1:0] {
    SIZE_WORD    = 2'd0,
    SIZE_HALF    = 2'd1,
    SIZE_BYTE    = 2'd2,
    SIZE_INVALID = 2'd3
  } size_e;

  // Store sequencer states
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_WRITE = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERR   = 3'd4
  } state_e;

  // True when an access of this size may start at this byte offset
  function automatic logic access_aligned(input logic [1:0] size,
                                          input logic [1:0] offset);
    logic ok;
    ok = 1'b0;
    case (size)
      SIZE_WORD: ok = (offset == 2'b00);
      SIZE_HALF: ok = (offset[0] == 1'b0);
      SIZE_BYTE: ok = 1'b1;
      default:   ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_write_encoder_store_lane_merge.sv
`default_nettype none
// ============================================================================
// Module      : store_lane_merge
// Description : Combinational big-endian lane merge. Places the store data
//               into the lanes selected by size/offset and keeps oldWord in
//               the remaining lanes; also reports the lanes written.
//               Lane 3 (mask bit 3) is bits [31:24].
// Revision    : 1.0 - initial release
// ============================================================================
module store_lane_merge
  import mem_write_encoder_pkg::*;
(
  input  logic [31:0] oldWord,
  input  logic [31:0] wrData,
  input  logic [1:0]  offset,
  input  logic [1:0]  dataSize,
  output logic [31:0] merged,
  output logic [3:0]  laneMask
);

  // Overlay the selected lanes onto the old word
  always_comb begin
    merged   = oldWord;
    laneMask = 4'b0000;
    case (dataSize)
      SIZE_WORD: begin
        merged   = wrData;
        laneMask = 4'b1111;
      end
      SIZE_HALF: begin
        if (offset[1]) begin
          merged[15:0] = wrData[15:0];
          laneMask     = 4'b0011;
        end else begin
          merged[31:16] = wrData[15:0];
          laneMask      = 4'b1100;
        end
      end
      SIZE_BYTE: begin
        case (offset)
          2'd0: begin merged[31:24] = wrData[7:0]; laneMask = 4'b1000; end
          2'd1: begin merged[23:16] = wrData[7:0]; laneMask = 4'b0100; end
          2'd2: begin merged[15:8]  = wrData[7:0]; laneMask = 4'b0010; end
          default: begin merged[7:0] = wrData[7:0]; laneMask = 4'b0001; end
        endcase
      end
      default: begin
        merged   = oldWord;
        laneMask = 4'b0000;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_write_encoder.sv
`default_nettype none
// ============================================================================
// Module      : mem_write_encoder
// Description : Store path for a word-wide big-endian data memory. Word
//               stores write directly; sub-word stores read-modify-write
//               because the memory has no byte enables. Each memory access
//               is a held req (memRe/memWe) completed by memAck.
//               Build option BYTE_ENABLE_EN: adds memBe, sub-word stores skip
//               the read and write the value replicated across all lanes.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_write_encoder
  import mem_write_encoder_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  reqValid,
  output logic                  reqReady,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           wrData,
  input  logic [1:0]            dataSize,
  output logic                  storeDone,
  output logic                  storeErr,
  output logic [ADDR_WIDTH-1:0] memAddr,
  output logic                  memRe,
  output logic                  memWe,
  output logic [31:0]           memWrData,
`ifdef BYTE_ENABLE_EN
  output logic [3:0]            memBe,
`endif
  input  logic [31:0]           memRdData,
  input  logic                  memAck
);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           data_q, data_d;
  logic [1:0]            size_q, size_d;
  logic [31:0]           rbuf_q, rbuf_d;

  logic [31:0]           merge_base;
  logic [31:0]           merged;
  logic [3:0]            lane_mask;

`ifdef BYTE_ENABLE_EN
  // Replicate the store value so every lane carries it; memBe picks lanes
  assign merge_base = (size_q == SIZE_HALF) ? {2{data_q[15:0]}} : {4{data_q[7:0]}};
`else
  // Unselected lanes come from the word read back from memory
  assign merge_base = rbuf_q;
`endif

  store_lane_merge u_merge (
    .oldWord  (merge_base),
    .wrData   (data_q),
    .offset   (addr_q[1:0]),
    .dataSize (size_q),
    .merged   (merged),
    .laneMask (lane_mask)
  );

  // Word-aligned address; held constant from the latched request
  assign memAddr   = {addr_q[ADDR_WIDTH-1:2], 2'b00};
  // Data is only driven during the write so it is zero otherwise
  assign memWrData = (state_q == ST_WRITE) ? merged : 32'h0;
`ifdef BYTE_ENABLE_EN
  assign memBe     = (state_q == ST_WRITE) ? lane_mask : 4'h0;
`endif

  // State and request registers; reset abandons any pending access
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      size_q  <= '0;
      rbuf_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      size_q  <= size_d;
      rbuf_q  <= rbuf_d;
    end
  end

  // Next-state logic and Moore outputs of the store sequencer
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    data_d    = data_q;
    size_d    = size_q;
    rbuf_d    = rbuf_q;
    reqReady  = 1'b0;
    memRe     = 1'b0;
    memWe     = 1'b0;
    storeDone = 1'b0;
    storeErr  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        reqReady = 1'b1;
        if (reqValid) begin
          addr_d = addr;
          data_d = wrData;
          size_d = dataSize;
          if (!access_aligned(dataSize, addr[1:0])) begin
            state_d = ST_ERR;
          end else if (dataSize == SIZE_WORD) begin
            state_d = ST_WRITE;
          end else begin
`ifdef BYTE_ENABLE_EN
            state_d = ST_WRITE;
`else
            state_d = ST_READ;
`endif
          end
        end
      end
      ST_READ: begin
        memRe = 1'b1;
        if (memAck) begin
          rbuf_d  = memRdData;
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        memWe = 1'b1;
        if (memAck) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        storeDone = 1'b1;
        state_d   = ST_IDLE;
      end
      ST_ERR: begin
        storeErr = 1'b1;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_write_encoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_write_encoder
// Description : Self-checking bench for mem_write_encoder. A vector table of
//               stores is driven; expected memory writes and completion
//               events are queued at drive time and compared by a monitor.
//               A memory model acks after a per-vector number of wait cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_write_encoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        reqValid;
  logic        reqReady;
  logic [31:0] addr;
  logic [31:0] wrData;
  logic [1:0]  dataSize;
  logic        storeDone;
  logic        storeErr;
  logic [31:0] memAddr;
  logic        memRe;
  logic        memWe;
  logic [31:0] memWrData;
  logic [3:0]  memBe;
  logic [31:0] memRdData;
  logic        memAck;

  always #5 clk = ~clk;

  mem_write_encoder #(.ADDR_WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .reqValid  (reqValid),
    .reqReady  (reqReady),
    .addr      (addr),
    .wrData    (wrData),
    .dataSize  (dataSize),
    .storeDone (storeDone),
    .storeErr  (storeErr),
    .memAddr   (memAddr),
    .memRe     (memRe),
    .memWe     (memWe),
    .memWrData (memWrData),
`ifdef BYTE_ENABLE_EN
    .memBe     (memBe),
`endif
    .memRdData (memRdData),
    .memAck    (memAck)
  );

`ifndef BYTE_ENABLE_EN
  assign memBe = 4'h0;
`endif

  // ---------------- memory model ----------------
  int          ack_delay = 0;
  int          ack_cnt;
  logic [31:0] rd_word = 32'h0;

  assign memAck    = (memRe || memWe) && (ack_cnt >= ack_delay);
  assign memRdData = rd_word;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          ack_cnt <= 0;
    else if ((memRe || memWe) && !memAck) ack_cnt <= ack_cnt + 1;
    else                                  ack_cnt <= 0;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  typedef struct {
    logic        err;
    logic [31:0] addr;
    logic [31:0] wr;
    logic [3:0]  be;
    int          reads;
    int          lat;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic [31:0] rd;
    int          delay;
    logic        err;
    logic [31:0] exp_wr;
    logic [3:0]  exp_be;
    int          reads;
    int          lat;
  } vec_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   evt_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: samples on the falling edge, away from the active edge
  initial begin : monitor
    int          acc_cyc, rd_cnt, wr_cnt, act_cnt;
    logic        prev_hold, prev_re, prev_end;
    logic [31:0] prev_addr, prev_wd;
    exp_t        e;
    acc_cyc = 0; rd_cnt = 0; wr_cnt = 0; act_cnt = 0;
    prev_hold = 1'b0; prev_re = 1'b0; prev_end = 1'b0;
    prev_addr = '0; prev_wd = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_hold = 1'b0;
        prev_end  = 1'b0;
      end else begin
        if (prev_end) chk("reqReady_after_pulse", {31'b0, reqReady}, 32'd1);
        prev_end = storeDone || storeErr;
        if (memRe || memWe) begin
          act_cnt++;
          chk("re_we_exclusive", {31'b0, memRe && memWe}, 32'd0);
          chk("reqReady_busy", {31'b0, reqReady}, 32'd0);
          if (prev_hold && (prev_re == memRe)) begin
            chk("held_addr_stable", memAddr, prev_addr);
            chk("held_data_stable", memWrData, prev_wd);
          end
          prev_hold = !memAck;
          prev_re   = memRe;
          prev_addr = memAddr;
          prev_wd   = memWrData;
        end else begin
          prev_hold = 1'b0;
        end
        if (memRe && memAck) begin
          rd_cnt++;
          if (exp_q.size() != 0) chk("read_addr", memAddr, exp_q[0].addr);
        end
        if (memWe && memAck) begin
          wr_cnt++;
          if (exp_q.size() != 0) begin
            chk("write_addr", memAddr, exp_q[0].addr);
            chk("write_data", memWrData, exp_q[0].wr);
`ifdef BYTE_ENABLE_EN
            chk("write_be", {28'b0, memBe}, {28'b0, exp_q[0].be});
`endif
          end
        end
        if (storeDone || storeErr) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_completion: got done=%0b err=%0b, expected none", storeDone, storeErr);
          end else begin
            e = exp_q.pop_front();
            chk("completion_kind", {31'b0, storeErr}, {31'b0, e.err});
            chk("latency", cyc - acc_cyc + 1, e.lat);
            chk("read_count", rd_cnt, e.reads);
            chk("write_count", wr_cnt, e.err ? 0 : 1);
            if (e.err) chk("err_mem_quiet", act_cnt, 0);
          end
          evt_cnt++;
        end
        if (reqValid && reqReady) begin
          acc_cyc = cyc;
          rd_cnt  = 0;
          wr_cnt  = 0;
          act_cnt = 0;
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic run_vec(input vec_t v);
    exp_t e;
    int   start;
    int   n;
    @(posedge clk);
    #1;
    addr      = v.addr;
    wrData    = v.wdata;
    dataSize  = v.size;
    rd_word   = v.rd;
    ack_delay = v.delay;
    e.err   = v.err;
    e.addr  = {v.addr[31:2], 2'b00};
    e.wr    = v.exp_wr;
    e.be    = v.exp_be;
    e.reads = v.reads;
    e.lat   = v.lat;
    exp_q.push_back(e);
    start    = evt_cnt;
    reqValid = 1'b1;
    @(posedge clk);
    #1 reqValid = 1'b0;
    n = 0;
    while (evt_cnt == start && n < 200) begin
      @(posedge clk);
      n++;
    end
    if (evt_cnt == start) begin
      checks++;
      errors++;
      $display("FAIL completion_timeout: got no storeDone/storeErr for addr 0x%08h, expected one within 200 cycles", v.addr);
      exp_q.delete();
    end
  endtask

  vec_t vecs[12];

  initial begin
    // addr, wdata, size, rd, delay, err, exp_wr, exp_be, reads, latency
`ifndef BYTE_ENABLE_EN
    vecs[0]  = '{32'h100, 32'hDEADBEEF, 2'd0, 32'h11223344, 0, 1'b0, 32'hDEADBEEF, 4'hF, 0, 3};
    vecs[1]  = '{32'h203, 32'h000000AA, 2'd2, 32'h11223344, 0, 1'b0, 32'h112233AA, 4'h1, 1, 4};
    vecs[2]  = '{32'h202, 32'h0000BEEF, 2'd1, 32'h11223344, 3, 1'b0, 32'h1122BEEF, 4'h3, 1, 10};
    vecs[6]  = '{32'h200, 32'h0000005A, 2'd2, 32'hAABBCCDD, 0, 1'b0, 32'h5ABBCCDD, 4'h8, 1, 4};
    vecs[7]  = '{32'h201, 32'h00000077, 2'd2, 32'h11223344, 1, 1'b0, 32'h11773344, 4'h4, 1, 6};
    vecs[8]  = '{32'h202, 32'h123456C3, 2'd2, 32'h11223344, 0, 1'b0, 32'h1122C344, 4'h2, 1, 4};
    vecs[9]  = '{32'h200, 32'hFFFFCAFE, 2'd1, 32'h11223344, 0, 1'b0, 32'hCAFE3344, 4'hC, 1, 4};
    vecs[11] = '{32'h201, 32'h00000055, 2'd2, 32'h11223344, 0, 1'b0, 32'h11553344, 4'h4, 1, 4};
`else
    vecs[0]  = '{32'h100, 32'hDEADBEEF, 2'd0, 32'h11223344, 0, 1'b0, 32'hDEADBEEF, 4'hF, 0, 3};
    vecs[1]  = '{32'h203, 32'h000000AA, 2'd2, 32'h11223344, 0, 1'b0, 32'hAAAAAAAA, 4'h1, 0, 3};
    vecs[2]  = '{32'h202, 32'h0000BEEF, 2'd1, 32'h11223344, 3, 1'b0, 32'hBEEFBEEF, 4'h3, 0, 6};
    vecs[6]  = '{32'h200, 32'h0000005A, 2'd2, 32'hAABBCCDD, 0, 1'b0, 32'h5A5A5A5A, 4'h8, 0, 3};
    vecs[7]  = '{32'h201, 32'h00000077, 2'd2, 32'h11223344, 1, 1'b0, 32'h77777777, 4'h4, 0, 4};
    vecs[8]  = '{32'h202, 32'h123456C3, 2'd2, 32'h11223344, 0, 1'b0, 32'hC3C3C3C3, 4'h2, 0, 3};
    vecs[9]  = '{32'h200, 32'hFFFFCAFE, 2'd1, 32'h11223344, 0, 1'b0, 32'hCAFECAFE, 4'hC, 0, 3};
    vecs[11] = '{32'h201, 32'h00000055, 2'd2, 32'h11223344, 0, 1'b0, 32'h55555555, 4'h4, 0, 3};
`endif
    vecs[3]  = '{32'h101, 32'h0000BEEF, 2'd1, 32'h11223344, 0, 1'b1, 32'h0, 4'h0, 0, 2};
    vecs[4]  = '{32'h102, 32'hDEADBEEF, 2'd0, 32'h11223344, 0, 1'b1, 32'h0, 4'h0, 0, 2};
    vecs[5]  = '{32'h100, 32'h12345678, 2'd3, 32'h11223344, 0, 1'b1, 32'h0, 4'h0, 0, 2};
    vecs[10] = '{32'h000, 32'h01234567, 2'd0, 32'h11223344, 2, 1'b0, 32'h01234567, 4'hF, 0, 5};
  end

  // ---------------- main sequence ----------------
  initial begin
    rst_n    = 1'b0;
    reqValid = 1'b0;
    addr     = '0;
    wrData   = '0;
    dataSize = '0;
    #1;
    chk("reset_reqReady", {31'b0, reqReady}, 32'd1);
    chk("reset_memRe", {31'b0, memRe}, 32'd0);
    chk("reset_memWe", {31'b0, memWe}, 32'd0);
    chk("reset_storeDone", {31'b0, storeDone}, 32'd0);
    chk("reset_storeErr", {31'b0, storeErr}, 32'd0);
    chk("reset_memAddr", memAddr, 32'h0);
    chk("reset_memWrData", memWrData, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 12; i++) run_vec(vecs[i]);

    // Reset while a sub-word store waits for its read ack
    @(posedge clk);
    #1;
    addr      = 32'h203;
    wrData    = 32'h000000AA;
    dataSize  = 2'd2;
    rd_word   = 32'h11223344;
    ack_delay = 20;
    reqValid  = 1'b1;
    @(posedge clk);
    #1 reqValid = 1'b0;
`ifndef BYTE_ENABLE_EN
    repeat (3) @(posedge clk);
    #3;
    chk("pre_reset_memRe", {31'b0, memRe}, 32'd1);
`else
    #3;
    chk("pre_reset_memWe", {31'b0, memWe}, 32'd1);
`endif
    rst_n = 1'b0;
    #1;
    chk("async_reset_memRe", {31'b0, memRe}, 32'd0);
    chk("async_reset_memWe", {31'b0, memWe}, 32'd0);
    chk("async_reset_reqReady", {31'b0, reqReady}, 32'd1);
    chk("async_reset_memAddr", memAddr, 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (6) @(posedge clk);
    run_vec(vecs[1]);
    run_vec(vecs[0]);

    repeat (3) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/mem_write_encoder.md
Name: mem_write_encoder

Overview:
- Store-path counterpart to the load data decoder.
- Accepts a store request (byte address, data, size) from the MEM stage and aligns the data onto a word-wide, big-endian data memory.
- The target memory has no byte enables, so sub-word stores use a read-modify-write sequence, driven by an FSM with a req/ack handshake on each memory access.

Parameters:
ADDR_WIDTH, 32, width of byte address and memAddr

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous reset, active-low
reqValid  input  1  store request valid
reqReady  output  1  high when a request can be accepted (IDLE only)
addr  input  ADDR_WIDTH  byte address of store
wrData  input  32  store data, right-justified (byte in [7:0], half in [15:0])
dataSize  input  2  0=word, 1=half, 2=byte, 3=invalid
storeDone  output  1  one-cycle pulse: store committed to memory
storeErr  output  1  one-cycle pulse: misaligned or invalid request, memory untouched
memAddr  output  ADDR_WIDTH  word address {addr[ADDR_WIDTH-1:2],2'b00}
memRe  output  1  memory read request, held until memAck
memWe  output  1  memory write request, held until memAck
memWrData  output  32  merged write word
memRdData  input  32  read data, valid in the cycle memAck is high during READ
memAck  input  1  memory completes current access

Behaviour:
- Reset (async, rst_n=0):
  - FSM goes to IDLE.
  - reqReady=1; memRe=0, memWe=0, storeDone=0, storeErr=0.
  - memAddr=0, memWrData=0, all latched fields cleared.
  - Applies immediately even mid-access; the pending memory op is abandoned.
- Accept: reqValid&&reqReady at a rising edge latches addr, wrData and dataSize; the FSM leaves IDLE the next cycle.
- Alignment check at accept:
  - word needs addr[1:0]=0.
  - half needs addr[1:0] in {0,2}.
  - byte: any offset.
  - size 3 is always invalid.
  - Failure goes to ERR.
- States:
  - IDLE: reqReady=1. Accept goes to WRITE (word), READ (half/byte) or ERR (bad).
  - READ: memRe=1. On memAck, capture memRdData into the merge buffer and go to WRITE.
  - WRITE: memWe=1 with memWrData=merged word (word store: wrData verbatim). On memAck go to DONE.
  - DONE: storeDone=1 for one cycle, then IDLE.
  - ERR: storeErr=1 for one cycle, then IDLE; memRe and memWe stay 0.
- Merge (big-endian, offset = addr[1:0]); unselected lanes keep the read word:
  - half@0 -> [31:16]=wrData[15:0]; half@2 -> [15:0].
  - byte@0 -> [31:24], @1 -> [23:16], @2 -> [15:8], @3 -> [7:0], from wrData[7:0].
- memRe and memWe are never high together. memAddr and memWrData are stable for the whole held access.
- memAck arriving in the same cycle the request is first asserted is legal (zero-wait memory).
- memAck outside READ/WRITE is ignored.
- Latency with zero-wait ack:
  - word store: 3 cycles accept-to-storeDone.
  - sub-word store: 4 cycles.
  - error: 2 cycles.
- reqValid while busy is not accepted; the requester must hold it.

Optional Feature:
- BYTE_ENABLE_EN
- Defined:
  - Adds output memBe[3:0] (bit3 = lane [31:24]).
  - Sub-word stores skip READ and go straight to WRITE.
  - memWrData carries the value replicated in all lanes (half duplicated, byte ×4); memBe selects the lanes.
  - Word stores use memBe=4'hF.
  - Sub-word latency becomes 3 cycles.
- Undefined: no memBe port; read-modify-write as above.

Decomposition:
- Shared package/header holds:
  - size encodings SIZE_WORD=0, SIZE_HALF=1, SIZE_BYTE=2.
  - FSM state encodings IDLE/READ/WRITE/DONE/ERR.
  - the alignment-check function (so the load decoder can report the same errors).
- One combinational sub-module: store_lane_merge.
  - Inputs: oldWord, wrData, offset, dataSize.
  - Outputs: merged word and lane mask (the mask drives memBe under BYTE_ENABLE_EN).

Test Plan:
- Word store, addr=0x100, wrData=0xDEADBEEF, zero-wait ack -> no memRe; memWe with memWrData=0xDEADBEEF at memAddr=0x100; storeDone 3 cycles after accept.
- Byte store addr=0x203, wrData=0x000000AA, memRdData=0x11223344 -> memRe then memWe with 0x112233AA at memAddr=0x200; storeDone 4 cycles after accept.
- Half store addr=0x202, wrData=0x0000BEEF, memRdData=0x11223344 -> memWrData=0x1122BEEF; with 3-cycle memAck delay on each access, memRe and memWe are held and storeDone comes 10 cycles after accept.
- Misaligned half addr=0x101, then word addr=0x102, then dataSize=3 -> storeErr pulse each, memRe=memWe=0 throughout, reqReady back the next cycle.
- rst_n dropped during READ with ack pending -> memRe=0 and reqReady=1 immediately, no storeDone; the next store completes normally.
- BYTE_ENABLE_EN: byte store addr=0x201, wrData=0x55 -> no memRe; memWrData=0x55555555, memBe=4'b0100; storeDone 3 cycles after accept.
